ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter that shares the single-port core RAM between the core's load/store path (port 0) and a secondary master such as a program loader or debug port (port 1). It performs at most one RAM access per cycle and drives the RAM's address, write-data and enable inputs. It registers read data back to the winning port. Arbitration is round-robin with a bounded burst: a port that keeps requesting cannot starve the other for more than MAX_BURST consecutive grants.

## Interface
- RAM_ADDR_WIDTH, 32, address width; matches the RAM.
- RAM_DATA_WIDTH, 32, data width; matches the RAM.
- MAX_BURST, 4, maximum consecutive grants one port may hold while the other is requesting; must be ≥1.

Clock and reset: one clock; reset is synchronous and active-high.

- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- p0Req / p1Req  in  1  access request; must be held, with its address and data, until granted.
- p0WriteEnable / p1WriteEnable  in  1  1 = write, 0 = read.
- p0Address / p1Address  in  RAM_ADDR_WIDTH  byte address.
- p0WriteData / p1WriteData  in  RAM_DATA_WIDTH  write data.
- p0Grant / p1Grant  out  1  combinational; the access completes in any cycle where Req && Grant.
- p0ReadData / p1ReadData  out  RAM_DATA_WIDTH  registered read data.
- p0ReadValid / p1ReadValid  out  1  one-cycle pulse; ReadData is valid while it is high.
- ramAddress  out  RAM_ADDR_WIDTH  to the RAM address input.
- ramWriteData  out  RAM_DATA_WIDTH  to the RAM write-data input.
- ramWriteEnable  out  1  to the RAM write-enable input.
- ramReadEnable  out  1  to the RAM read-enable input.
- ramReadData  in  RAM_DATA_WIDTH  from the RAM; combinational, and high-Z when not read-enabled.

## Operation
- **States:** IDLE, OWN0, OWN1. Auxiliary registers: lastOwner (1 bit) and burstCount, which is $clog2(MAX_BURST+1) bits and saturates at MAX_BURST.
- **One requester:** that port is granted, whatever the state or count.
- **Both requesting, state OWNk with burstCount < MAX_BURST:** port k is granted.
- **Both requesting, state OWNk with burstCount ≥ MAX_BURST:** the other port is granted.
- **Both requesting, state IDLE:** the port other than lastOwner is granted.
- **After a grant to port k:** next state is OWNk and lastOwner = k. burstCount becomes burstCount+1 (saturating) if the state was already OWNk, otherwise 1.
- **No request:** next state is IDLE, burstCount = 0, lastOwner is held.
- **RAM drive when port k is granted:** ramAddress and ramWriteData come from port k. ramWriteEnable = pkWriteEnable and ramReadEnable = !pkWriteEnable.
- **RAM drive with no grant:** ramAddress = 0, ramWriteData = 0, both enables = 0.
- **Read return:** on a granted read, ramReadData is captured into pkReadData at the granting edge, and pkReadValid = 1 for the following cycle only.
- ReadData holds its last value otherwise, and is never loaded from an ungranted cycle, so the RAM's high-Z output is never captured.
- **Writes:** take effect at the RAM on the granting edge. A read granted in the next cycle returns the new data.

## Timing
- **Grant latency:** 0 cycles when uncontested; request to grant is combinational in the same cycle.
- **Read latency:** ReadValid and ReadData appear 1 cycle after the grant.
- **Throughput:** one access per cycle, and back-to-back grants to the same port are allowed.
- **Worst-case wait:** MAX_BURST cycles under continuous contention.
- **Reset values:** state IDLE, burstCount 0, lastOwner 1 (so port 0 wins the first contest), both ReadValid 0, both ReadData 0.
- While reset is high, both Grants, ramWriteEnable and ramReadEnable are 0, and ramAddress and ramWriteData are 0.
- **Reset mid-operation:** a read granted in the cycle before reset asserts does not produce ReadValid after the reset edge. There is no partial write, because a write completes at its granting edge.
- Dropping a request before it is granted is a protocol violation; the bench must flag it.

## Structure
- Shared package mem_arb_pkg holds:
  - the state encodings (IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2);
  - the port index constants PORT_CORE = 0 and PORT_AUX = 1.
- One sub-module, arb_read_return: the per-port ReadData/ReadValid register, instantiated twice. All arbitration logic stays in ram_arbiter.

## Test plan
- **Reset:** reset high for 2 cycles with both requests high -> grants, enables and ReadValid all 0. Then, in the first cycle after reset, p0Grant = 1.
- **Single port:** p0 writes 0xDEADBEEF to 0x10, then reads 0x10 in the next cycle -> p0ReadValid pulses 1 cycle after the read grant with 0xDEADBEEF, and p1 signals stay quiet.
- **Contention, MAX_BURST = 4:** both ports request continuously for 12 cycles -> grant pattern 0,0,0,0,1,1,1,1,0,0,0,0.
- **Late arrival:** p0 requests alone for 6 cycles, then p1 joins -> p1 is granted in the very next cycle (burstCount is saturated).
- **Idle round-robin:** last grant to p1, one idle cycle, then both request -> p0 is granted first. Repeat with last grant to p0 -> p1 is granted first.
- **Reset mid-read:** p1 read is granted, then reset is asserted the next cycle -> p1ReadValid stays 0 and p1ReadData = 0 after the reset edge.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the core RAM arbiter: FSM state encodings and port indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arbState_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_AUX  = 1'b1;

endpackage

// File: rtl/arb_read_return.sv
// Per-port read-return register: captures RAM read data on a granted read and
// raises a one-cycle valid pulse alongside it.
module arb_read_return
  import mem_arb_pkg::*;
#(
  parameter int RAM_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      capture,
  input  logic [RAM_DATA_WIDTH-1:0] ramReadData,
  output logic [RAM_DATA_WIDTH-1:0] readData,
  output logic                      readValid
);

  logic [RAM_DATA_WIDTH-1:0] readData_p1;
  logic                      vld_p1;

  // Stage p1: data loads only on a granted read, so high-Z from an idle RAM never lands here.
  always_ff @(posedge clk) begin
    if (reset) begin
      readData_p1 <= '0;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= capture;
      if (capture) begin
        readData_p1 <= ramReadData;
      end
    end
  end

  assign readData  = readData_p1;
  assign readValid = vld_p1;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter with bounded bursts sharing the single-port core RAM
// between the core load/store path (port 0) and an auxiliary master (port 1).
module ram_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 32,
  parameter int RAM_DATA_WIDTH = 32,
  parameter int MAX_BURST      = 4
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      p0Req,
  input  logic                      p0WriteEnable,
  input  logic [RAM_ADDR_WIDTH-1:0] p0Address,
  input  logic [RAM_DATA_WIDTH-1:0] p0WriteData,
  output logic                      p0Grant,
  output logic [RAM_DATA_WIDTH-1:0] p0ReadData,
  output logic                      p0ReadValid,

  input  logic                      p1Req,
  input  logic                      p1WriteEnable,
  input  logic [RAM_ADDR_WIDTH-1:0] p1Address,
  input  logic [RAM_DATA_WIDTH-1:0] p1WriteData,
  output logic                      p1Grant,
  output logic [RAM_DATA_WIDTH-1:0] p1ReadData,
  output logic                      p1ReadValid,

  output logic [RAM_ADDR_WIDTH-1:0] ramAddress,
  output logic [RAM_DATA_WIDTH-1:0] ramWriteData,
  output logic                      ramWriteEnable,
  output logic                      ramReadEnable,
  input  logic [RAM_DATA_WIDTH-1:0] ramReadData
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAX_CNT = BW'(MAX_BURST);

  arbState_t     state, stateNext;
  logic [BW-1:0] burstCount, burstCountNext;
  logic          lastOwner, lastOwnerNext;
  logic          grant0, grant1;

  function automatic logic [BW-1:0] satInc(input logic [BW-1:0] c);
    return (c >= MAX_CNT) ? MAX_CNT : c + BW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      burstCount <= '0;
      lastOwner  <= PORT_AUX;
    end else begin
      state      <= stateNext;
      burstCount <= burstCountNext;
      lastOwner  <= lastOwnerNext;
    end
  end

  // Winner selection: a lone requester always wins; contention honours the burst limit.
  always_comb begin
    grant0         = 1'b0;
    grant1         = 1'b0;
    stateNext      = IDLE;
    burstCountNext = '0;
    lastOwnerNext  = lastOwner;

    if (!reset) begin
      if (p0Req && p1Req) begin
        case (state)
          OWN0: begin
            grant0 = (burstCount < MAX_CNT);
            grant1 = !(burstCount < MAX_CNT);
          end
          OWN1: begin
            grant1 = (burstCount < MAX_CNT);
            grant0 = !(burstCount < MAX_CNT);
          end
          default: begin
            grant0 = (lastOwner == PORT_AUX);
            grant1 = (lastOwner == PORT_CORE);
          end
        endcase
      end else begin
        grant0 = p0Req;
        grant1 = p1Req;
      end

      if (grant0) begin
        stateNext      = OWN0;
        lastOwnerNext  = PORT_CORE;
        burstCountNext = (state == OWN0) ? satInc(burstCount) : BW'(1);
      end else if (grant1) begin
        stateNext      = OWN1;
        lastOwnerNext  = PORT_AUX;
        burstCountNext = (state == OWN1) ? satInc(burstCount) : BW'(1);
      end
    end
  end

  always_comb begin
    ramAddress     = '0;
    ramWriteData   = '0;
    ramWriteEnable = 1'b0;
    ramReadEnable  = 1'b0;
    if (grant0) begin
      ramAddress     = p0Address;
      ramWriteData   = p0WriteData;
      ramWriteEnable = p0WriteEnable;
      ramReadEnable  = !p0WriteEnable;
    end else if (grant1) begin
      ramAddress     = p1Address;
      ramWriteData   = p1WriteData;
      ramWriteEnable = p1WriteEnable;
      ramReadEnable  = !p1WriteEnable;
    end
  end

  assign p0Grant = grant0;
  assign p1Grant = grant1;

  arb_read_return #(.RAM_DATA_WIDTH(RAM_DATA_WIDTH)) uReturn0 (
    .clk         (clk),
    .reset       (reset),
    .capture     (grant0 && !p0WriteEnable),
    .ramReadData (ramReadData),
    .readData    (p0ReadData),
    .readValid   (p0ReadValid)
  );

  arb_read_return #(.RAM_DATA_WIDTH(RAM_DATA_WIDTH)) uReturn1 (
    .clk         (clk),
    .reset       (reset),
    .capture     (grant1 && !p1WriteEnable),
    .ramReadData (ramReadData),
    .readData    (p1ReadData),
    .readValid   (p1ReadValid)
  );

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM model.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0Req, p0WriteEnable, p1Req, p1WriteEnable;
  logic [31:0] p0Address, p0WriteData, p1Address, p1WriteData;
  logic        p0Grant, p1Grant, p0ReadValid, p1ReadValid;
  logic [31:0] p0ReadData, p1ReadData;
  logic [31:0] ramAddress, ramWriteData;
  logic        ramWriteEnable, ramReadEnable;
  logic [31:0] mem [0:255];
  wire  [31:0] ramReadData = ramReadEnable ? mem[ramAddress[7:0]] : 32'bz;

  int tests = 0;
  int fails = 0;
  logic pend0 = 1'b0, pend1 = 1'b0;

  always #5 clk = ~clk;

  ram_arbiter #(.RAM_ADDR_WIDTH(32), .RAM_DATA_WIDTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .p0Req(p0Req), .p0WriteEnable(p0WriteEnable), .p0Address(p0Address),
    .p0WriteData(p0WriteData), .p0Grant(p0Grant), .p0ReadData(p0ReadData),
    .p0ReadValid(p0ReadValid),
    .p1Req(p1Req), .p1WriteEnable(p1WriteEnable), .p1Address(p1Address),
    .p1WriteData(p1WriteData), .p1Grant(p1Grant), .p1ReadData(p1ReadData),
    .p1ReadValid(p1ReadValid),
    .ramAddress(ramAddress), .ramWriteData(ramWriteData),
    .ramWriteEnable(ramWriteEnable), .ramReadEnable(ramReadEnable),
    .ramReadData(ramReadData)
  );

  always @(posedge clk) begin
    if (ramWriteEnable) mem[ramAddress[7:0]] <= ramWriteData;
  end

  // A request must stay up until it has been granted.
  always @(negedge clk) begin
    if (pend0 && !p0Req) begin
      fails++;
      $display("FAIL protocol_p0_drop: req=%0b while pending, required 1", p0Req);
    end
    if (pend1 && !p1Req) begin
      fails++;
      $display("FAIL protocol_p1_drop: req=%0b while pending, required 1", p1Req);
    end
    pend0 = p0Req && !p0Grant && !reset;
    pend1 = p1Req && !p1Grant && !reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    p0Req = 1'b1; p0WriteEnable = 1'b0; p0Address = 32'h40;
    p1Req = 1'b1; p1WriteEnable = 1'b0; p1Address = 32'h44;
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge clk);
      tests++;
      if ({p0Grant, p1Grant, ramWriteEnable, ramReadEnable, p0ReadValid, p1ReadValid} !== 6'b0) begin
        fails++;
        $display("FAIL reset_ctrl: grants/enables/valids=%b required 000000",
                 {p0Grant, p1Grant, ramWriteEnable, ramReadEnable, p0ReadValid, p1ReadValid});
      end
      tests++;
      if (ramAddress !== 32'h0 || p0ReadData !== 32'h0 || p1ReadData !== 32'h0) begin
        fails++;
        $display("FAIL reset_data: addr=%h rd0=%h rd1=%h required all 0",
                 ramAddress, p0ReadData, p1ReadData);
      end
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (p0Grant !== 1'b1 || p1Grant !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_grant: g0=%b g1=%b required g0=1 g1=0", p0Grant, p1Grant);
    end
    tick();
    p0Req = 1'b0;
    @(negedge clk);
    tests++;
    if (p1Grant !== 1'b1 || p0ReadValid !== 1'b1) begin
      fails++;
      $display("FAIL reset_followup: g1=%b rv0=%b required 1 1", p1Grant, p0ReadValid);
    end
    tick();
    p1Req = 1'b0;
    @(negedge clk);
    tests++;
    if (ramAddress !== 32'h0 || ramWriteData !== 32'h0 || ramReadEnable !== 1'b0 ||
        ramWriteEnable !== 1'b0 || p1ReadValid !== 1'b1 || p0ReadValid !== 1'b0) begin
      fails++;
      $display("FAIL idle_drive: addr=%h wd=%h re=%b we=%b rv0=%b rv1=%b required 0 0 0 0 0 1",
               ramAddress, ramWriteData, ramReadEnable, ramWriteEnable, p0ReadValid, p1ReadValid);
    end
  endtask

  task automatic test_single_port();
    tick();
    p0Req = 1'b1; p0WriteEnable = 1'b1; p0Address = 32'h10; p0WriteData = 32'hDEADBEEF;
    @(negedge clk);
    tests++;
    if (p0Grant !== 1'b1 || ramWriteEnable !== 1'b1 || ramReadEnable !== 1'b0 ||
        ramAddress !== 32'h10 || ramWriteData !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL sp_write: g0=%b we=%b re=%b addr=%h wd=%h required 1 1 0 00000010 deadbeef",
               p0Grant, ramWriteEnable, ramReadEnable, ramAddress, ramWriteData);
    end
    tick();
    p0WriteEnable = 1'b0;
    @(negedge clk);
    tests++;
    if (p0Grant !== 1'b1 || ramReadEnable !== 1'b1 || ramWriteEnable !== 1'b0 || p0ReadValid !== 1'b0) begin
      fails++;
      $display("FAIL sp_read_grant: g0=%b re=%b we=%b rv0=%b required 1 1 0 0",
               p0Grant, ramReadEnable, ramWriteEnable, p0ReadValid);
    end
    tick();
    p0Req = 1'b0;
    @(negedge clk);
    tests++;
    if (p0ReadValid !== 1'b1 || p0ReadData !== 32'hDEADBEEF || p1ReadValid !== 1'b0 || p1Grant !== 1'b0) begin
      fails++;
      $display("FAIL sp_read_data: rv0=%b rd0=%h rv1=%b g1=%b required 1 deadbeef 0 0",
               p0ReadValid, p0ReadData, p1ReadValid, p1Grant);
    end
    tick();
    @(negedge clk);
    tests++;
    if (p0ReadValid !== 1'b0 || p0ReadData !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL sp_hold: rv0=%b rd0=%h required 0 deadbeef", p0ReadValid, p0ReadData);
    end
  endtask

  task automatic test_contention();
    logic expect1 [12];
    expect1 = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    tick();
    p1Req = 1'b1; p1WriteEnable = 1'b0; p1Address = 32'h84;
    tick();
    p1Req = 1'b0;
    tick();
    p0Req = 1'b1; p0WriteEnable = 1'b0; p0Address = 32'h80;
    p1Req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tests++;
      if (p1Grant !== expect1[i] || p0Grant !== !expect1[i]) begin
        fails++;
        $display("FAIL contention_cycle%0d: g0=%b g1=%b required g1=%b", i, p0Grant, p1Grant, expect1[i]);
      end
      tick();
    end
    p0Req = 1'b0;
    @(negedge clk);
    tick();
    p1Req = 1'b0;
  endtask

  task automatic test_late_arrival();
    tick();
    p0Req = 1'b1; p0WriteEnable = 1'b0; p0Address = 32'h90;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++;
      if (p0Grant !== 1'b1) begin
        fails++;
        $display("FAIL late_p0_alone%0d: g0=%b required 1", i, p0Grant);
      end
      tick();
    end
    p1Req = 1'b1; p1WriteEnable = 1'b0; p1Address = 32'h94;
    @(negedge clk);
    tests++;
    if (p1Grant !== 1'b1 || p0Grant !== 1'b0) begin
      fails++;
      $display("FAIL late_join: g0=%b g1=%b required 0 1", p0Grant, p1Grant);
    end
    tick();
    p1Req = 1'b0;
    @(negedge clk);
    tests++;
    if (p0Grant !== 1'b1) begin
      fails++;
      $display("FAIL late_resume: g0=%b required 1", p0Grant);
    end
    tick();
    p0Req = 1'b0;
  endtask

  task automatic test_idle_rr();
    p1Req = 1'b1;
    tick();
    p1Req = 1'b0;
    tick();
    p0Req = 1'b1; p1Req = 1'b1;
    @(negedge clk);
    tests++;
    if (p0Grant !== 1'b1 || p1Grant !== 1'b0) begin
      fails++;
      $display("FAIL rr_after_p1: g0=%b g1=%b required 1 0", p0Grant, p1Grant);
    end
    tick();
    p0Req = 1'b0;
    tick();
    p1Req = 1'b0;
    p0Req = 1'b1;
    tick();
    p0Req = 1'b0;
    tick();
    p0Req = 1'b1; p1Req = 1'b1;
    @(negedge clk);
    tests++;
    if (p1Grant !== 1'b1 || p0Grant !== 1'b0) begin
      fails++;
      $display("FAIL rr_after_p0: g0=%b g1=%b required 0 1", p0Grant, p1Grant);
    end
    tick();
    p1Req = 1'b0;
    tick();
    p0Req = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    tick();
    p1Req = 1'b1; p1WriteEnable = 1'b1; p1Address = 32'h20; p1WriteData = 32'h12345678;
    tick();
    p1WriteEnable = 1'b0;
    @(negedge clk);
    tests++;
    if (p1Grant !== 1'b1 || ramReadEnable !== 1'b1) begin
      fails++;
      $display("FAIL mid_read_grant: g1=%b re=%b required 1 1", p1Grant, ramReadEnable);
    end
    tick();
    p1Req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (p1ReadData !== 32'h12345678 || p1Grant !== 1'b0 || ramReadEnable !== 1'b0) begin
      fails++;
      $display("FAIL mid_read_capture: rd1=%h g1=%b re=%b required 12345678 0 0",
               p1ReadData, p1Grant, ramReadEnable);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (p1ReadValid !== 1'b0 || p1ReadData !== 32'h0) begin
      fails++;
      $display("FAIL mid_read_reset: rv1=%b rd1=%h required 0 00000000", p1ReadValid, p1ReadData);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    reset = 1'b1;
    p0Req = 1'b0; p0WriteEnable = 1'b0; p0Address = '0; p0WriteData = '0;
    p1Req = 1'b0; p1WriteEnable = 1'b0; p1Address = '0; p1WriteData = '0;
    test_reset();
    test_single_port();
    test_contention();
    test_late_arrival();
    test_idle_rr();
    test_reset_mid_read();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
